// File: rtl/rpn_stack_controller_pkg.sv
// Shared encodings for the RPN calculator: command types, error codes,
// sequencer states and ALU opcodes (shared with the ALU decoder).
package rpn_stack_controller_pkg;

  typedef enum logic [1:0] {
    CMD_PUSH  = 2'b00,
    CMD_OP    = 2'b01,
    CMD_DROP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int unsigned ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] ALU_ADD    = 3'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB    = 3'd1;
  localparam logic [ALU_OPW-1:0] ALU_AND    = 3'd2;
  localparam logic [ALU_OPW-1:0] ALU_OR     = 3'd3;
  localparam logic [ALU_OPW-1:0] ALU_XOR    = 3'd4;
  localparam logic [ALU_OPW-1:0] ALU_PASS_A = 3'd5;

endpackage

// File: rtl/rpn_stack_controller_bank.sv
// Operand stack storage: DEPTH x WIDTH registers with per-entry load
// enables, synchronous clear, asynchronous reset, and read ports for the
// top and second entries given the current stack pointer.
module rpn_stack_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] sp,
  output logic [WIDTH-1:0]           top_data,
  output logic [WIDTH-1:0]           second_data
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] load_en;

  // Decode the write index into one load enable per entry
  always_comb begin
    load_en = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      load_en[i] = wr_en && (wr_idx == IW'(i));
    end
  end

  // Entry registers: only enabled entries load, clear zeroes them all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (load_en[i]) mem[i] <= wr_data;
      end
    end
  end

  // Top and second reads; unoccupied positions read as zero
  always_comb begin
    top_data    = '0;
    second_data = '0;
    if (sp >= CW'(1)) top_data    = mem[IW'(sp - CW'(1))];
    if (sp >= CW'(2)) second_data = mem[IW'(sp - CW'(2))];
  end

endmodule

// File: rtl/rpn_stack_controller.sv
// RPN calculator sequencer: accepts PUSH/OP/DROP/CLEAR over valid/ready,
// owns the stack pointer, and drives registered operands/opcode to the
// external combinational ALU, writing its result back as the new top.
module rpn_stack_controller
  import rpn_stack_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [WIDTH-1:0]           cmd_data,
  input  logic [OPW-1:0]             cmd_op,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [OPW-1:0]             alu_op,
  input  logic [WIDTH-1:0]           alu_result,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  state_e           state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d;
  logic             ready_en_q;
  logic             done_q, done_d;
  err_e             err_q, err_d;
  logic             accept;
  logic             op_go;
  logic             load_ops;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             bank_clear;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] second_data;

  assign cmd_ready = ready_en_q && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (sp_q == CW'(DEPTH));
  assign empty     = (sp_q == '0);
  assign op_go     = accept && (cmd_e'(cmd_type) == CMD_OP) && (sp_q >= CW'(2));
  assign depth_cnt = sp_q;
  assign top       = top_data;
  assign done      = done_q;
  assign err       = err_q;

  rpn_stack_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (bank_clear),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .sp          (sp_q),
    .top_data    (top_data),
    .second_data (second_data)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: OP runs IDLE -> EXEC (ALU settle) -> WB -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op_go) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state command decode: stack writes, pointer update, status
  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_data    = cmd_data;
    bank_clear = 1'b0;
    sp_d       = sp_q;
    done_d     = 1'b0;
    err_d      = err_q;
    load_ops   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = ERR_NONE;
          case (cmd_e'(cmd_type))
            CMD_PUSH: begin
              if (full) begin
                err_d = ERR_OVERFLOW;
              end else begin
                wr_en  = 1'b1;
                wr_idx = IW'(sp_q);
                sp_d   = sp_q + CW'(1);
                done_d = 1'b1;
              end
            end
            CMD_OP: begin
              if (sp_q < CW'(2)) err_d = ERR_UNDERFLOW;
              else               load_ops = 1'b1;
            end
            CMD_DROP: begin
              if (empty) begin
                err_d = ERR_UNDERFLOW;
              end else begin
                sp_d   = sp_q - CW'(1);
                done_d = 1'b1;
              end
            end
            CMD_CLEAR: begin
              bank_clear = 1'b1;
              sp_d       = '0;
              done_d     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_WB: begin
        wr_en   = 1'b1;
        wr_idx  = IW'(sp_q - CW'(2));
        wr_data = alu_result;
        sp_d    = sp_q - CW'(1);
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer, status and ALU operand registers; ready_en keeps the
  // handshake closed for the whole reset period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q       <= '0;
      ready_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      sp_q       <= sp_d;
      ready_en_q <= 1'b1;
      done_q     <= done_d;
      err_q      <= err_d;
      if (load_ops) begin
        alu_a  <= second_data;
        alu_b  <= top_data;
        alu_op <= cmd_op;
      end
    end
  end

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Directed bench for rpn_stack_controller with a behavioural ALU.
module tb_rpn_stack_controller;
  import rpn_stack_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic [2:0] cmd_op;
  logic [7:0] alu_a, alu_b, alu_result, top;
  logic [2:0] alu_op;
  logic [2:0] depth_cnt;
  logic       full, empty, done;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_stack_controller #(.WIDTH(8), .DEPTH(4), .OPW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_data   (cmd_data),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .top        (top),
    .depth_cnt  (depth_cnt),
    .full       (full),
    .empty      (empty),
    .done       (done),
    .err        (err)
  );

  // External ALU model
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
  end

  typedef struct {
    logic [1:0] ctype;
    logic [7:0] data;
    logic [2:0] op;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] etop;
    logic [2:0] edepth;
    logic [1:0] eerr;
    logic       edone;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] t, input logic [7:0] d, input logic [2:0] o,
                              input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] etop,
                              input logic [2:0] edepth, input logic [1:0] eerr, input logic edone);
    vec_t v;
    v.ctype = t; v.data = d; v.op = o; v.ea = ea; v.eb = eb;
    v.etop = etop; v.edepth = edepth; v.eerr = eerr; v.edone = edone;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] etop, input logic [2:0] edepth,
                           input logic [1:0] eerr, input logic edone);
    chk({tag, " top"},   32'(top),       32'(etop));
    chk({tag, " depth"}, 32'(depth_cnt), 32'(edepth));
    chk({tag, " err"},   32'(err),       32'(eerr));
    chk({tag, " done"},  32'(done),      32'(edone));
    chk({tag, " full"},  32'(full),      32'(edepth == 3'd4));
    chk({tag, " empty"}, 32'(empty),     32'(edepth == 3'd0));
  endtask

  // Present a command, wait (bounded) for ready, leave at #1 after the accepting edge
  task automatic issue(input logic [1:0] t, input logic [7:0] d, input logic [2:0] o);
    int unsigned n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d; cmd_op = o;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0; cmd_op = '0;

    // type, data, op, ea, eb, top, depth, err, done
    vecs.push_back(mk(CMD_PUSH,  8'd5,   '0,      8'd0, 8'd0,   8'd5,   3'd1, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd3,   '0,      8'd0, 8'd0,   8'd3,   3'd2, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_SUB, 8'd5, 8'd3,   8'd2,   3'd1, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_DROP,  8'd0,   '0,      8'd0, 8'd0,   8'd0,   3'd0, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_ADD, 8'd0, 8'd0,   8'd0,   3'd0, 2'd2, 1'b0));
    vecs.push_back(mk(CMD_PUSH,  8'd7,   '0,      8'd0, 8'd0,   8'd7,   3'd1, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_DROP,  8'd0,   '0,      8'd0, 8'd0,   8'd0,   3'd0, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_DROP,  8'd0,   '0,      8'd0, 8'd0,   8'd0,   3'd0, 2'd2, 1'b0));
    vecs.push_back(mk(CMD_PUSH,  8'd1,   '0,      8'd0, 8'd0,   8'd1,   3'd1, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd2,   '0,      8'd0, 8'd0,   8'd2,   3'd2, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd3,   '0,      8'd0, 8'd0,   8'd3,   3'd3, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd4,   '0,      8'd0, 8'd0,   8'd4,   3'd4, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd9,   '0,      8'd0, 8'd0,   8'd4,   3'd4, 2'd1, 1'b0));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_ADD, 8'd3, 8'd4,   8'd7,   3'd3, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_XOR, 8'd2, 8'd7,   8'd5,   3'd2, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'hFF,  '0,      8'd0, 8'd0,   8'hFF,  3'd3, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_ADD, 8'd5, 8'hFF,  8'h04,  3'd2, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_SUB, 8'd1, 8'h04,  8'hFD,  3'd1, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_CLEAR, 8'd0,   '0,      8'd0, 8'd0,   8'd0,   3'd0, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_OP,    8'd0,   ALU_OR,  8'd0, 8'd0,   8'd0,   3'd0, 2'd2, 1'b0));
    vecs.push_back(mk(CMD_CLEAR, 8'd0,   '0,      8'd0, 8'd0,   8'd0,   3'd0, 2'd0, 1'b1));
    vecs.push_back(mk(CMD_PUSH,  8'd6,   '0,      8'd0, 8'd0,   8'd6,   3'd1, 2'd0, 1'b1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(cmd_ready), 32'd0);
    chk("reset alu_a", 32'(alu_a), 32'd0);
    chk("reset alu_b", 32'(alu_b), 32'd0);
    chk("reset alu_op", 32'(alu_op), 32'd0);
    chk_state("reset", 8'd0, 3'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ready", 32'(cmd_ready), 32'd1);

    // Table-driven command sequence
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      issue(vecs[i].ctype, vecs[i].data, vecs[i].op);
      @(negedge clk);
      if (vecs[i].ctype == CMD_OP && vecs[i].edone) begin
        chk({tag, " alu_a"}, 32'(alu_a), 32'(vecs[i].ea));
        chk({tag, " alu_b"}, 32'(alu_b), 32'(vecs[i].eb));
        chk({tag, " alu_op"}, 32'(alu_op), 32'(vecs[i].op));
        chk({tag, " exec done"}, 32'(done), 32'd0);
        chk({tag, " exec ready"}, 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk({tag, " wb done"}, 32'(done), 32'd0);
        @(negedge clk);
      end
      chk_state(tag, vecs[i].etop, vecs[i].edepth, vecs[i].eerr, vecs[i].edone);
    end

    // Valid held through an OP: next command accepted once, right after WB
    issue(CMD_PUSH, 8'd2, '0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = CMD_OP; cmd_op = ALU_SUB;
    chk("hold ready idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_type = CMD_PUSH; cmd_data = 8'h11;
    @(negedge clk);
    chk("hold exec ready", 32'(cmd_ready), 32'd0);
    chk("hold exec a", 32'(alu_a), 32'd6);
    chk("hold exec b", 32'(alu_b), 32'd2);
    @(negedge clk);
    chk("hold wb ready", 32'(cmd_ready), 32'd0);
    chk("hold wb depth", 32'(depth_cnt), 32'd2);
    @(negedge clk);
    chk("hold after-wb ready", 32'(cmd_ready), 32'd1);
    chk_state("hold result", 8'd4, 3'd1, 2'd0, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk_state("hold push", 8'h11, 3'd2, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("hold idle", 8'h11, 3'd2, 2'd0, 1'b0);

    // Reset during EXEC aborts the op
    issue(CMD_PUSH, 8'd8, '0);
    issue(CMD_PUSH, 8'd2, '0);
    issue(CMD_OP, 8'd0, ALU_ADD);
    @(negedge clk);
    chk("abort exec a", 32'(alu_a), 32'd8);
    chk("abort exec b", 32'(alu_b), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort ready", 32'(cmd_ready), 32'd0);
    chk("abort alu_a", 32'(alu_a), 32'd0);
    chk_state("abort", 8'd0, 3'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort release ready", 32'(cmd_ready), 32'd1);
    chk_state("abort release", 8'd0, 3'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk_state("abort no wb", 8'd0, 3'd0, 2'd0, 1'b0);

    // CLEAR after three pushes: single DONE pulse, stack usable afterwards
    issue(CMD_PUSH, 8'd1, '0);
    issue(CMD_PUSH, 8'd2, '0);
    issue(CMD_PUSH, 8'd3, '0);
    @(negedge clk);
    chk_state("pre-clear", 8'd3, 3'd3, 2'd0, 1'b1);
    issue(CMD_CLEAR, 8'd0, '0);
    @(negedge clk);
    chk_state("clear", 8'd0, 3'd0, 2'd0, 1'b1);
    @(negedge clk);
    chk("clear pulse end", 32'(done), 32'd0);
    issue(CMD_PUSH, 8'd6, '0);
    @(negedge clk);
    chk_state("clear push", 8'd6, 3'd1, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
